// File: rtl/biasb_buf_pkg.sv
// rtl/biasb_buf_pkg.sv - FSM encodings and sizing helpers shared by the bias buffer
package biasb_buf_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  function automatic int fifo_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/biasb_rd_fifo.sv
// rtl/biasb_rd_fifo.sv - read-return FIFO with registered count and full/empty flags
module biasb_rd_fifo
  import biasb_buf_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int DW    = 512
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [DW-1:0] store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = store[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + 1'b1;
    else if (!do_push && do_pop)
      count_nxt = count - 1'b1;
  end

  // Storage is reset so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        store[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/biasb_sram2p_buf.sv
// rtl/biasb_sram2p_buf.sv - bias buffer: 1W/1R array with byte writes, forwarding,
// credit-limited read return and a zero-fill clear engine
module biasb_sram2p_buf
  import biasb_buf_pkg::*;
#(
  parameter int AW         = 7,
  parameter int DW         = 512,
  parameter int RD_LAT     = 1,
  parameter int CLR_ON_RST = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [DW/8-1:0] wr_be,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  output logic            wr_rdy,
  input  logic            rd_req,
  input  logic [AW-1:0]   rd_addr,
  output logic            rd_req_rdy,
  output logic            rd_vld,
  output logic [DW-1:0]   rd_data,
  input  logic            rd_rdy,
  input  logic            clr_start,
  output logic            init_busy
);

  localparam int DP = 2 ** AW;
  localparam int BW = DW / 8;
  localparam int FD = fifo_depth(RD_LAT);
  localparam int OW = cnt_width(FD);

  logic [1:0]    state;
  logic          boot;
  logic [AW-1:0] clr_addr;
  logic [OW-1:0] outstanding;
  logic [DW-1:0] mem [DP];
  logic [DW-1:0] rd_word;
  logic          idle_open;
  logic          wr_acc;
  logic          rd_acc;
  logic          pop;
  logic          fifo_empty;
  logic          push;
  logic [DW-1:0] push_data;

  // boot marks the first cycle after reset release, where the clear decision is made.
  assign idle_open  = (state == ST_IDLE) && !boot;
  assign wr_rdy     = idle_open;
  assign rd_req_rdy = idle_open && (outstanding < OW'(FD));
  assign init_busy  = (state == ST_CLEAR);
  assign wr_acc     = wr_en & wr_rdy;
  assign rd_acc     = rd_req & rd_req_rdy;
  assign rd_vld     = ~fifo_empty;
  assign pop        = rd_vld & rd_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      boot     <= 1'b1;
      clr_addr <= '0;
    end else begin
      boot <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (boot) begin
            if (CLR_ON_RST != 0)
              state <= ST_CLEAR;
          end else if (clr_start) begin
            state <= (outstanding == '0) ? ST_CLEAR : ST_DRAIN;
          end
        end
        ST_DRAIN: if (outstanding == '0) state <= ST_CLEAR;
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (&clr_addr)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      outstanding <= '0;
    else if (rd_acc && !pop)
      outstanding <= outstanding + 1'b1;
    else if (!rd_acc && pop)
      outstanding <= outstanding - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < BW; i++)
        if (wr_be[i])
          mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
    end
  end

  // Array read with write-first merge of a same-cycle write to the same word.
  always_comb begin
    rd_word = mem[rd_addr];
    if (wr_acc && (wr_addr == rd_addr)) begin
      for (int i = 0; i < BW; i++)
        if (wr_be[i])
          rd_word[i*8 +: 8] = wr_data[i*8 +: 8];
    end
  end

  // The merged word is captured at accept, so later writes never leak into the return.
  generate
    if (RD_LAT <= 1) begin : g_lat1
      assign push      = rd_acc;
      assign push_data = rd_word;
    end else begin : g_lat2
      logic          pipe_vld;
      logic [DW-1:0] pipe_data;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_vld  <= 1'b0;
          pipe_data <= '0;
        end else begin
          pipe_vld  <= rd_acc;
          pipe_data <= rd_word;
        end
      end
      assign push      = pipe_vld;
      assign push_data = pipe_data;
    end
  endgenerate

  biasb_rd_fifo #(
    .DEPTH (FD),
    .DW    (DW)
  ) u_rd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (rd_data),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_biasb_sram2p_buf.sv
// tb/tb_biasb_sram2p_buf.sv - directed self-checking bench for biasb_sram2p_buf
module tb_biasb_sram2p_buf;

  localparam int AW     = 7;
  localparam int DW     = 512;
  localparam int BW     = DW / 8;
  localparam int RD_LAT = 2;
  localparam int DP     = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [BW-1:0] wr_be = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_rdy;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_req_rdy;
  logic          rd_vld;
  logic [DW-1:0] rd_data;
  logic          rd_rdy = 1'b1;
  logic          clr_start = 1'b0;
  logic          init_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  biasb_sram2p_buf #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .CLR_ON_RST(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_req_rdy(rd_req_rdy),
    .rd_vld(rd_vld), .rd_data(rd_data), .rd_rdy(rd_rdy),
    .clr_start(clr_start), .init_busy(init_busy)
  );

  function automatic logic [DW-1:0] pat(input int i);
    logic [7:0] b;
    b = 8'(8'h40 + i);
    return {BW{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(output int dly, output int len);
    dly = 0;
    while (!init_busy && dly < 10) begin tick(); dly++; end
    len = 0;
    while (init_busy && len < 300) begin tick(); len++; end
  endtask

  task automatic write_word(input int a, input logic [BW-1:0] be, input logic [DW-1:0] d);
    int n;
    n = 0;
    while (!wr_rdy && n < 400) begin tick(); n++; end
    checks++;
    if (!wr_rdy) begin errors++; $display("FAIL write_wait got wr_rdy %0b exp 1", wr_rdy); end
    wr_en = 1'b1; wr_addr = AW'(a); wr_be = be; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_word(input int a, output logic [DW-1:0] d, output int lat);
    int n;
    rd_rdy = 1'b1; rd_req = 1'b1; rd_addr = AW'(a);
    n = 0;
    while (!rd_req_rdy && n < 400) begin tick(); n++; end
    tick();
    rd_req = 1'b0;
    lat = 1;
    while (!rd_vld && lat < 20) begin tick(); lat++; end
    if (!rd_vld) lat = -1;
    d = rd_data;
    tick();
  endtask

  task automatic test_reset();
    int dly, len;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({wr_rdy, rd_req_rdy, rd_vld, init_busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {wr_rdy, rd_req_rdy, rd_vld, init_busy});
    end
    checks++;
    if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    rst_n = 1'b1;
    count_busy(dly, len);
    checks++;
    if (dly !== 1) begin errors++; $display("FAIL boot_clear_delay got %0d exp 1", dly); end
    checks++;
    if (len !== DP) begin errors++; $display("FAIL boot_clear_len got %0d exp %0d", len, DP); end
    checks++;
    if (wr_rdy !== 1'b1) begin errors++; $display("FAIL post_clear_wr_rdy got %0b exp 1", wr_rdy); end
  endtask

  task automatic test_read_all_zero();
    logic [DW-1:0] d;
    int lat, bad;
    bad = 0;
    for (int a = 0; a < DP; a++) begin
      read_word(a, d, lat);
      if (d !== '0 || lat !== RD_LAT) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL read_all_zero got %0d bad words exp 0", bad); end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] d;
    int lat;
    write_word(5, '1, {BW{8'hA5}});
    read_word(5, d, lat);
    checks++;
    if (d !== {BW{8'hA5}}) begin errors++; $display("FAIL wr_rd_data got %h exp a5..", d); end
    checks++;
    if (lat !== RD_LAT) begin errors++; $display("FAIL rd_latency got %0d exp %0d", lat, RD_LAT); end
    write_word(5, '0, '1);
    read_word(5, d, lat);
    checks++;
    if (d !== {BW{8'hA5}}) begin errors++; $display("FAIL be_zero_noop got %h exp a5..", d); end
  endtask

  task automatic test_forward();
    logic [DW-1:0] d, exp;
    int lat, n;
    write_word(9, '1, {BW{8'h11}});
    exp = {BW{8'h11}};
    exp[7:0] = 8'h77;
    wr_en = 1'b1; wr_addr = AW'(9); wr_be = BW'(1); wr_data = {BW{8'h77}};
    rd_req = 1'b1; rd_addr = AW'(9); rd_rdy = 1'b1;
    checks++;
    if ({wr_rdy, rd_req_rdy} !== 2'b11) begin
      errors++; $display("FAIL fwd_ready got %b exp 11", {wr_rdy, rd_req_rdy});
    end
    tick();
    wr_en = 1'b0; rd_req = 1'b0;
    n = 0;
    while (!rd_vld && n < 20) begin tick(); n++; end
    checks++;
    if (rd_data !== exp || !rd_vld) begin errors++; $display("FAIL fwd_merge got %h exp %h", rd_data, exp); end
    tick();
    // a write one cycle after the read accept must not reach the returned data
    rd_req = 1'b1; rd_addr = AW'(9);
    tick();
    rd_req = 1'b0;
    wr_en = 1'b1; wr_addr = AW'(9); wr_be = '1; wr_data = {BW{8'h33}};
    tick();
    wr_en = 1'b0;
    n = 0;
    while (!rd_vld && n < 20) begin tick(); n++; end
    checks++;
    if (rd_data !== exp || !rd_vld) begin errors++; $display("FAIL later_write_hidden got %h exp %h", rd_data, exp); end
    tick();
    read_word(9, d, lat);
    checks++;
    if (d !== {BW{8'h33}}) begin errors++; $display("FAIL later_write_stored got %h exp 33..", d); end
  endtask

  task automatic test_backpressure();
    int acc, pops, bad, first, last;
    for (int i = 0; i < 8; i++) write_word(20 + i, '1, pat(i));
    rd_rdy = 1'b0; acc = 0;
    for (int c = 0; c < 12; c++) begin
      rd_req = 1'b1; rd_addr = AW'(20 + acc);
      if (rd_req_rdy) acc++;
      tick();
    end
    checks++;
    if (acc !== RD_LAT + 2) begin errors++; $display("FAIL bp_accepts got %0d exp %0d", acc, RD_LAT + 2); end
    checks++;
    if (rd_req_rdy !== 1'b0) begin errors++; $display("FAIL bp_req_rdy got %0b exp 0", rd_req_rdy); end
    checks++;
    if (rd_vld !== 1'b1 || rd_data !== pat(0)) begin
      errors++; $display("FAIL bp_hold got vld %0b data %h exp %h", rd_vld, rd_data, pat(0));
    end
    rd_rdy = 1'b1; pops = 0; bad = 0; first = -1; last = -1;
    for (int c = 0; c < 24; c++) begin
      rd_req = (acc < 8); rd_addr = AW'(20 + acc);
      if (rd_vld) begin
        if (rd_data !== pat(pops)) bad++;
        pops++;
      end
      if (rd_req && rd_req_rdy) begin
        if (first < 0) first = c;
        last = c;
        acc++;
      end
      tick();
    end
    rd_req = 1'b0;
    checks++;
    if (pops !== 8 || bad !== 0) begin errors++; $display("FAIL bp_order got pops %0d bad %0d exp 8 0", pops, bad); end
    checks++;
    if (first !== 1 || last !== 4) begin
      errors++; $display("FAIL bp_sustained got first %0d last %0d exp 1 4", first, last);
    end
  endtask

  task automatic test_clear_drain();
    logic [DW-1:0] d;
    int lat, pops, bad, len, n;
    rd_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin rd_req = 1'b1; rd_addr = AW'(20 + i); tick(); end
    rd_req = 1'b0;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    checks++;
    if ({init_busy, wr_rdy, rd_req_rdy} !== 3'b000) begin
      errors++; $display("FAIL drain_flags got %b exp 000", {init_busy, wr_rdy, rd_req_rdy});
    end
    wr_en = 1'b1; wr_addr = AW'(5); wr_be = '1; wr_data = '1; clr_start = 1'b1;
    tick();
    wr_en = 1'b0; clr_start = 1'b0;
    repeat (4) tick();
    checks++;
    if (init_busy !== 1'b0) begin errors++; $display("FAIL drain_hold got busy %0b exp 0", init_busy); end
    rd_rdy = 1'b1; pops = 0; bad = 0; n = 0;
    while (!init_busy && n < 20) begin
      if (rd_vld) begin
        if (rd_data !== pat(pops)) bad++;
        pops++;
      end
      tick(); n++;
    end
    checks++;
    if (pops !== 3 || bad !== 0 || !init_busy) begin
      errors++; $display("FAIL drain_pops got pops %0d bad %0d busy %0b exp 3 0 1", pops, bad, init_busy);
    end
    len = 0;
    while (init_busy && len < 300) begin
      clr_start = (len == 10);
      wr_en = (len == 20); wr_addr = '0; wr_be = '1; wr_data = '1;
      if (len == 20) begin
        checks++;
        if (wr_rdy !== 1'b0) begin errors++; $display("FAIL clear_wr_rdy got %0b exp 0", wr_rdy); end
      end
      tick(); len++;
    end
    clr_start = 1'b0; wr_en = 1'b0;
    checks++;
    if (len !== DP) begin errors++; $display("FAIL clear_len got %0d exp %0d", len, DP); end
    bad = 0;
    read_word(0, d, lat);  if (d !== '0) bad++;
    read_word(5, d, lat);  if (d !== '0) bad++;
    read_word(9, d, lat);  if (d !== '0) bad++;
    read_word(21, d, lat); if (d !== '0) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL clear_zeroed got %0d bad exp 0", bad); end
  endtask

  task automatic test_reset_mid_clear();
    int dly, len;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    checks++;
    if (init_busy !== 1'b1) begin errors++; $display("FAIL idle_clr_start got busy %0b exp 1", init_busy); end
    repeat (60) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({init_busy, wr_rdy, rd_req_rdy, rd_vld} !== 4'b0000 || rd_data !== '0) begin
      errors++; $display("FAIL mid_clear_reset got %b data %h exp 0000 0",
                         {init_busy, wr_rdy, rd_req_rdy, rd_vld}, rd_data);
    end
    tick(); tick();
    rst_n = 1'b1;
    count_busy(dly, len);
    checks++;
    if (dly !== 1 || len !== DP) begin
      errors++; $display("FAIL restart_clear got dly %0d len %0d exp 1 %0d", dly, len, DP);
    end
  endtask

  initial begin
    test_reset();
    test_read_all_zero();
    test_write_read();
    test_forward();
    test_backpressure();
    test_clear_drain();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
